wb_sram_burst_slave: RTL and testbench

- Wishbone B4 memory target hung off one slave port (s0/s1/s2) of the wb interconnect; consumes the muxed ADR/DAT_W/SEL/WE/CYC/STB/CTI/BTE it produces and returns ACK/ERR/DAT_R.
- Byte-enabled single-port SRAM with registered-feedback bursts (CTI incrementing/constant, BTE linear/wrap4/8/16), configurable first-beat wait states, ERR on out-of-range access.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_if.sv | 27 ++
 rtl/wb_sram_burst_slave_mem.sv | 29 ++
 rtl/wb_sram_burst_slave.sv | 165 ++++++++++++++++
 tb/tb_wb_sram_burst_slave.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 encodings and the SRAM target's FSM state type.
package wb_pkg;

  // Cycle type identifiers (CTI)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions (BTE)
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CLASSIC_ACK,
    ST_BURST
  } state_t;

  // A first beat with one of these CTIs opens a registered-feedback burst.
  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_INCR) || (cti == CTI_CONST);
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle as seen at one interconnect slave port.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ADR;
  logic [DATA_WIDTH-1:0]   DAT_W;
  logic [DATA_WIDTH-1:0]   DAT_R;
  logic [DATA_WIDTH/8-1:0] SEL;
  logic                    WE;
  logic                    CYC;
  logic                    STB;
  logic [2:0]              CTI;
  logic [1:0]              BTE;
  logic                    ACK;
  logic                    ERR;

  modport slave (
    input  ADR, DAT_W, SEL, WE, CYC, STB, CTI, BTE,
    output DAT_R, ACK, ERR
  );

  modport master (
    output ADR, DAT_W, SEL, WE, CYC, STB, CTI, BTE,
    input  DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_burst_slave_mem.sv
// Byte-enabled single-port RAM with a registered read port. The read
// register returns zero whenever no read is requested, so it can drive
// the bus read-data directly.
module wb_sram_burst_slave_mem #(
  parameter int DEPTH = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NB-1:0]         be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Lane-masked write and one-cycle read; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata <= re ? mem[addr] : '0;
  end
endmodule

// File: rtl/wb_sram_burst_slave.sv
// Wishbone B4 SRAM target: classic and registered-feedback bursts
// (constant / incrementing, linear or wrap4/8/16), optional first-beat
// wait states, ERR termination on out-of-range beats.
module wb_sram_burst_slave
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter int WAIT_STATES = 0
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int BYTES = WB_DATA_WIDTH / 8;
  localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_L = AW'(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                   state, state_nxt;
  logic [3:0]               wait_cnt;
  logic [AW-1:0]            burst_idx;
  logic [2:0]               mode_cti;
  logic [1:0]               mode_bte;
  logic                     ack, err;

  logic                     req;
  logic                     below_base;
  logic [AW-1:0]            req_off, req_idx, beat_idx;
  logic [2:0]               beat_cti;
  logic [1:0]               beat_bte;
  logic                     beat_oor;
  logic                     issue, ack_nxt, err_nxt;
  logic                     mem_we, mem_re;
  logic [WB_DATA_WIDTH-1:0] rdata;

  // Index of the beat after idx: constant bursts hold, wrap bursts roll
  // over inside their aligned 4/8/16-word block, linear bursts just count.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                             input logic [2:0] cti,
                                             input logic [1:0] bte);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc = idx + AW'(1);
    case (bte)
      BTE_WRAP4:  mask = AW'(3);
      BTE_WRAP8:  mask = AW'(7);
      BTE_WRAP16: mask = AW'(15);
      default:    mask = '1;
    endcase
    if (cti == CTI_CONST) return idx;
    return (idx & ~mask) | (inc & mask);
  endfunction

  assign req = s.CYC & s.STB;

  // Decode the master's address; the borrow out flags ADR below the base.
  always_comb begin
    {below_base, req_off} = {1'b0, s.ADR} - {1'b0, ADDR_BASE};
    req_idx = req_off >> SHIFT;
    // Inside a burst the internal address is authoritative.
    if (state == ST_BURST) begin
      beat_idx = burst_idx;
      beat_cti = mode_cti;
      beat_bte = mode_bte;
    end else begin
      beat_idx = req_idx;
      beat_cti = s.CTI;
      beat_bte = s.BTE;
    end
    beat_oor = ((state != ST_BURST) && below_base) || (beat_idx >= DEPTH_L);
  end

  // State, counters, burst address and registered bus responses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      burst_idx <= '0;
      mode_cti  <= CTI_CLASSIC;
      mode_bte  <= BTE_LINEAR;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
      if (state == ST_IDLE && req) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (issue) begin
        burst_idx <= next_idx(beat_idx, beat_cti, beat_bte);
        if (state != ST_BURST) begin
          mode_cti <= s.CTI;
          mode_bte <= s.BTE;
        end
      end
    end
  end

  // Next-state decision; an erroring first beat terminates like a classic one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES != 0) state_nxt = ST_WAIT;
          else if (!beat_oor && is_burst_cti(s.CTI)) state_nxt = ST_BURST;
          else state_nxt = ST_CLASSIC_ACK;
        end
      end
      ST_WAIT: begin
        if (!s.CYC) state_nxt = ST_IDLE;
        else if (wait_cnt == 4'd0 && s.STB) begin
          if (!beat_oor && is_burst_cti(s.CTI)) state_nxt = ST_BURST;
          else state_nxt = ST_CLASSIC_ACK;
        end
      end
      ST_CLASSIC_ACK: state_nxt = ST_IDLE;
      ST_BURST: begin
        if (!s.CYC) state_nxt = ST_IDLE;
        else if (s.STB && (beat_oor || s.CTI == CTI_EOB)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beat issue: ACK or ERR for next cycle plus the RAM strobes.
  always_comb begin
    issue = 1'b0;
    case (state)
      ST_IDLE:  issue = req && (WAIT_STATES == 0);
      ST_WAIT:  issue = req && (wait_cnt == 4'd0);
      ST_BURST: issue = req;
      default:  issue = 1'b0;
    endcase
    ack_nxt = issue && !beat_oor;
    err_nxt = issue && beat_oor;
    mem_we  = ack_nxt && s.WE && rstn;
    mem_re  = ack_nxt && !s.WE && rstn;
  end

  wb_sram_burst_slave_mem #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (WB_DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (s.SEL),
    .addr  (beat_idx[IDX_W-1:0]),
    .wdata (s.DAT_W),
    .re    (mem_re),
    .rdata (rdata)
  );

  assign s.ACK   = ack;
  assign s.ERR   = err;
  assign s.DAT_R = rdata;
endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Scoreboard bench for wb_sram_burst_slave: dut0 without wait states,
// dut1 with three. Expected beats carry the cycle they must appear in.
module tb_wb_sram_burst_slave;
  typedef struct {
    int          at;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  wb_sram_burst_slave #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH(1024),
    .ADDR_BASE(32'h0), .WAIT_STATES(0)
  ) dut0 (.clk(clk), .rstn(rstn), .s(bus0));

  wb_sram_burst_slave #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH(1024),
    .ADDR_BASE(32'h0), .WAIT_STATES(3)
  ) dut1 (.clk(clk), .rstn(rstn), .s(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, input logic c,
                       input logic st, input logic [2:0] cti, input logic [1:0] bte);
    if (w == 0) begin
      bus0.ADR = adr; bus0.DAT_W = dat; bus0.SEL = sel; bus0.WE = we;
      bus0.CYC = c; bus0.STB = st; bus0.CTI = cti; bus0.BTE = bte;
    end else begin
      bus1.ADR = adr; bus1.DAT_W = dat; bus1.SEL = sel; bus1.WE = we;
      bus1.CYC = c; bus1.STB = st; bus1.CTI = cti; bus1.BTE = bte;
    end
  endtask

  task automatic idle(input int w);
    drive(w, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
  endtask

  task automatic push(input int w, input int at, input bit e, input bit chk,
                      input logic [31:0] d);
    exp_t x;
    x.at = at; x.err = e; x.chk = chk; x.data = d;
    if (w == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  // Classic single access; ACK expected after lat cycles, then one idle cycle.
  task automatic classic(input int w, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input bit e,
                         input logic [31:0] rd);
    int lat;
    lat = (w == 0) ? 1 : 4;
    push(w, cyc + lat, e, !we || e, e ? 32'h0 : rd);
    drive(w, adr, dat, sel, we, 1'b1, 1'b1, 3'b000, 2'b00);
    repeat (lat + 1) tick();
    idle(w);
  endtask

  // Registered-feedback burst on dut0; beats after the first present a
  // decoy ADR since the target must use its own address.
  task automatic burst(input logic [31:0] adr, input logic [1:0] bte,
                       input logic [2:0] cti0, input logic we, input int n,
                       input bit eob, input logic [31:0] wd [4],
                       input logic [31:0] rd [4], input bit er [4]);
    for (int i = 0; i < n; i++) begin
      logic [2:0] cti;
      cti = (eob && i == n - 1) ? 3'b111 : cti0;
      push(0, cyc + 1, er[i], !we || er[i], er[i] ? 32'h0 : rd[i]);
      drive(0, (i == 0) ? adr : 32'h300, wd[i], 4'hF, we, 1'b1, 1'b1, cti, bte);
      tick();
    end
    idle(0);
    tick();
  endtask

  // Monitor: every ACK/ERR pops one expectation; quiet cycles must be all-zero.
  always @(negedge clk) begin
    logic        a, e;
    logic [31:0] d;
    exp_t        x;
    if (mon_en) begin
      for (int w = 0; w < 2; w++) begin
        a = (w == 0) ? bus0.ACK : bus1.ACK;
        e = (w == 0) ? bus0.ERR : bus1.ERR;
        d = (w == 0) ? bus0.DAT_R : bus1.DAT_R;
        vectors++;
        if (a === 1'b1 || e === 1'b1) begin
          if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
            miscompares++;
            $display("FAIL unexpected_beat dut%0d cyc %0d: got ack=%b err=%b dat=%h, want no beat",
                     w, cyc, a, e, d);
          end else begin
            x = (w == 0) ? q0.pop_front() : q1.pop_front();
            if (x.at != cyc || e !== x.err || a !== !x.err || (x.chk && d !== x.data)) begin
              miscompares++;
              $display("FAIL beat dut%0d: got cyc %0d ack=%b err=%b dat=%h, want cyc %0d err=%b dat=%h",
                       w, cyc, a, e, d, x.at, x.err, x.chk ? x.data : d);
            end
          end
        end else if (a !== 1'b0 || e !== 1'b0 || d !== 32'h0) begin
          miscompares++;
          $display("FAIL quiet_outputs dut%0d cyc %0d: got ack=%b err=%b dat=%h, want 0/0/0",
                   w, cyc, a, e, d);
        end
      end
    end
  end

  initial begin
    logic [31:0] wd [4];
    logic [31:0] rd [4];
    bit          er [4];
    int          c;

    idle(0);
    idle(1);
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;

    // Reset state of both targets
    vectors++;
    if (bus0.ACK !== 1'b0 || bus0.ERR !== 1'b0 || bus0.DAT_R !== 32'h0 ||
        bus1.ACK !== 1'b0 || bus1.ERR !== 1'b0 || bus1.DAT_R !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %b%b/%h %b%b/%h, want 00/0 00/0",
               bus0.ACK, bus0.ERR, bus0.DAT_R, bus1.ACK, bus1.ERR, bus1.DAT_R);
    end
    mon_en = 1'b1;
    tick();

    // Back-to-back classic write/read, byte-lane merge, out-of-range read
    classic(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEADBEEF);
    classic(0, 32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(0, 32'h20, 32'h0000AB00, 4'b0010, 1'b1, 1'b0, 32'h0);
    classic(0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h1122AB44);
    classic(0, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
    classic(0, 32'h14, 32'h55555555, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(0, 32'h18, 32'h66666666, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(0, 32'h1C, 32'h77770007, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(0, 32'hFF8, 32'h3FE03FE0, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(0, 32'hFFC, 32'h3FF03FF0, 4'hF, 1'b1, 1'b0, 32'h0);
    tick();

    // Wrap4 incrementing read from idx 6: indices 6,7,4,5
    wd = '{32'h0, 32'h0, 32'h0, 32'h0};
    rd = '{32'h66666666, 32'h77770007, 32'hDEADBEEF, 32'h55555555};
    er = '{1'b0, 1'b0, 1'b0, 1'b0};
    burst(32'h18, 2'b01, 3'b010, 1'b0, 4, 1'b1, wd, rd, er);
    tick();

    // Constant-address read burst on idx 8
    rd = '{32'h1122AB44, 32'h1122AB44, 32'h1122AB44, 32'h0};
    burst(32'h20, 2'b00, 3'b001, 1'b0, 3, 1'b1, wd, rd, er);
    tick();

    // Linear read from idx 1022 runs off the end: ACK, ACK, ERR
    rd = '{32'h3FE03FE0, 32'h3FF03FF0, 32'h0, 32'h0};
    er = '{1'b0, 1'b0, 1'b1, 1'b0};
    burst(32'hFF8, 2'b00, 3'b010, 1'b0, 3, 1'b0, wd, rd, er);
    tick();

    // Linear write burst from idx 16 with a two-cycle STB pause after beat 2
    c = cyc;
    push(0, c + 1, 1'b0, 1'b0, 32'h0);
    drive(0, 32'h40, 32'hA0A00000, 4'hF, 1'b1, 1'b1, 1'b1, 3'b010, 2'b00);
    tick();
    push(0, c + 2, 1'b0, 1'b0, 32'h0);
    drive(0, 32'h300, 32'hA0A00001, 4'hF, 1'b1, 1'b1, 1'b1, 3'b010, 2'b00);
    tick();
    drive(0, 32'h300, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, 3'b010, 2'b00);
    repeat (2) tick();
    push(0, c + 5, 1'b0, 1'b0, 32'h0);
    drive(0, 32'h300, 32'hA0A00002, 4'hF, 1'b1, 1'b1, 1'b1, 3'b010, 2'b00);
    tick();
    push(0, c + 6, 1'b0, 1'b0, 32'h0);
    drive(0, 32'h300, 32'hA0A00003, 4'hF, 1'b1, 1'b1, 1'b1, 3'b111, 2'b00);
    tick();
    idle(0);
    tick();
    classic(0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA0A00000);
    classic(0, 32'h44, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA0A00001);
    classic(0, 32'h48, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA0A00002);
    classic(0, 32'h4C, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA0A00003);
    classic(0, 32'h300, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
    tick();

    // Reset asserted in the middle of a read burst
    c = cyc;
    push(0, c + 1, 1'b0, 1'b1, 32'hA0A00000);
    drive(0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 3'b010, 2'b00);
    tick();
    push(0, c + 2, 1'b0, 1'b1, 32'hA0A00001);
    drive(0, 32'h300, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 3'b010, 2'b00);
    tick();
    rstn = 1'b0;
    tick();
    vectors++;
    if (bus0.ACK !== 1'b0 || bus0.ERR !== 1'b0 || bus0.DAT_R !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_burst: got ack=%b err=%b dat=%h, want 0/0/0",
               bus0.ACK, bus0.ERR, bus0.DAT_R);
    end
    idle(0);
    rstn = 1'b1;
    tick();
    classic(0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA0A00000);
    classic(0, 32'h48, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA0A00002);
    classic(0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEADBEEF);
    tick();

    // Three wait states: ACK in the fourth cycle after the request is sampled
    classic(1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0);
    classic(1, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, 32'hCAFEF00D);
    tick();

    // CYC dropped while waiting: no beat at all, target back in IDLE
    drive(1, 32'h8, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00);
    repeat (2) tick();
    idle(1);
    repeat (6) tick();
    classic(1, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, 32'hCAFEF00D);
    classic(1, 32'h2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);

    repeat (6) tick();
    vectors++;
    if (q0.size() != 0) begin
      miscompares++;
      $display("FAIL pending_dut0: got %0d beats outstanding, want 0", q0.size());
    end
    vectors++;
    if (q1.size() != 0) begin
      miscompares++;
      $display("FAIL pending_dut1: got %0d beats outstanding, want 0", q1.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
